// File: rtl/entity_pkg.sv
// Shared types and constants for the entity descriptor writer.
// Descriptor layout: [13:10] ID, [9:8] orientation, [7:0] tile.
package entity_pkg;

    localparam int ENTITY_W      = 14;
    localparam int ID_HI         = 13;
    localparam int ID_LO         = 10;
    localparam int ORIENT_HI     = 9;
    localparam int ORIENT_LO     = 8;
    localparam int TILE_HI       = 7;
    localparam int TILE_LO       = 0;
    localparam int NUM_SLOTS_DEF = 9;
    localparam int N_LIVE        = 9;
    localparam int SLOT_W        = 4;

    localparam logic [ENTITY_W-1:0] EMPTY_ENTITY = 14'h3C00;

    typedef logic [ENTITY_W-1:0] entity_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/commit_trigger.sv
// Raster position compare; emits one trig pulse on the rising
// edge of the match, however long the counters dwell there.
module commit_trigger #(
    parameter int COMMIT_V = 480,
    parameter int COMMIT_H = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_V,
    input  logic [9:0] counter_H,
    output logic       trig
);

    logic match;
    logic match_q;

    assign match = (counter_V == 10'(COMMIT_V)) &&
                   (counter_H == 10'(COMMIT_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    assign trig = match && !match_q;

endmodule

// File: rtl/entity_scene_writer.sv
// Shadow bank of entity descriptors, copied atomically to the
// live outputs once per frame during vertical blanking.
module entity_scene_writer
    import entity_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int COMMIT_V  = 480,
    parameter int COMMIT_H  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [SLOT_W-1:0]   wr_slot,
    input  logic [ENTITY_W-1:0] wr_entity,
    input  logic                clear_req,
    input  logic [9:0]          counter_V,
    input  logic [9:0]          counter_H,
    output logic [ENTITY_W-1:0] entity_1,
    output logic [ENTITY_W-1:0] entity_2,
    output logic [ENTITY_W-1:0] entity_3,
    output logic [ENTITY_W-1:0] entity_4,
    output logic [ENTITY_W-1:0] entity_5,
    output logic [ENTITY_W-1:0] entity_6,
    output logic [ENTITY_W-1:0] entity_7_Array,
    output logic [ENTITY_W-1:0] entity_8_Flip,
    output logic [ENTITY_W-1:0] entity_9_Flip,
    output logic                frame_committed,
    output logic                wr_err
);

    state_e  state_q, state_d;
    entity_t shadow_q [N_LIVE];
    entity_t shadow_d [N_LIVE];
    entity_t live_q   [N_LIVE];
    entity_t live_d   [N_LIVE];
    logic    dirty_q, dirty_d;
    logic    cpend_q, cpend_d;
    logic    clrp_q, clrp_d;
    logic    fc_q, fc_d;
    logic    err_q, err_d;
    logic    rdy_en_q;
    logic    trig;
    logic    wr_fire;
    logic    slot_ok;

    commit_trigger #(
        .COMMIT_V (COMMIT_V),
        .COMMIT_H (COMMIT_H)
    ) u_trig (
        .clk       (clk),
        .rst_n     (reset),
        .counter_V (counter_V),
        .counter_H (counter_H),
        .trig      (trig)
    );

    // rdy_en_q holds ready low until the first edge after release
    assign wr_ready = rdy_en_q && (state_q == ST_IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign slot_ok  = int'(wr_slot) < NUM_SLOTS;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        live_d   = live_q;
        dirty_d  = dirty_q;
        cpend_d  = cpend_q || trig;
        clrp_d   = clrp_q;
        fc_d     = 1'b0;
        err_d    = 1'b0;

        if (wr_fire) begin
            if (slot_ok) begin
                shadow_d[wr_slot] = wr_entity;
                dirty_d           = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clear_req || clrp_q) begin
                    state_d = ST_CLEAR;
                    clrp_d  = 1'b0;
                end else if (cpend_q) begin
                    if (dirty_q) begin
                        state_d = ST_COMMIT;
                    end
                    cpend_d = trig;
                end
            end
            ST_CLEAR: begin
                shadow_d = '{default: EMPTY_ENTITY};
                dirty_d  = 1'b1;
                state_d  = ST_IDLE;
                clrp_d   = clrp_q || clear_req;
            end
            ST_COMMIT: begin
                live_d  = shadow_q;
                dirty_d = 1'b0;
                fc_d    = 1'b1;
                state_d = ST_IDLE;
                clrp_d  = clrp_q || clear_req;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '{default: EMPTY_ENTITY};
            live_q   <= '{default: EMPTY_ENTITY};
            dirty_q  <= 1'b0;
            cpend_q  <= 1'b0;
            clrp_q   <= 1'b0;
            fc_q     <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            dirty_q  <= dirty_d;
            cpend_q  <= cpend_d;
            clrp_q   <= clrp_d;
            fc_q     <= fc_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign entity_1        = live_q[0];
    assign entity_2        = live_q[1];
    assign entity_3        = live_q[2];
    assign entity_4        = live_q[3];
    assign entity_5        = live_q[4];
    assign entity_6        = live_q[5];
    assign entity_7_Array  = live_q[6];
    assign entity_8_Flip   = live_q[7];
    assign entity_9_Flip   = live_q[8];
    assign frame_committed = fc_q;
    assign wr_err          = err_q;

endmodule

// File: tb/tb_entity_scene_writer.sv
// Directed bench for entity_scene_writer: reset, commits,
// bad-slot writes, clear vs. commit, and reset during commit.
module tb_entity_scene_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_slot = 4'd0;
    logic [13:0] wr_entity = 14'd0;
    logic        clear_req = 1'b0;
    logic [9:0]  counter_V = 10'd0;
    logic [9:0]  counter_H = 10'd0;
    logic [13:0] e1, e2, e3, e4, e5, e6, e7, e8, e9;
    logic        frame_committed;
    logic        wr_err;

    int checks   = 0;
    int failures = 0;
    int fc_cnt   = 0;

    localparam logic [13:0] EMP = 14'h3C00;

    entity_scene_writer dut (
        .clk             (clk),
        .reset           (reset),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_slot         (wr_slot),
        .wr_entity       (wr_entity),
        .clear_req       (clear_req),
        .counter_V       (counter_V),
        .counter_H       (counter_H),
        .entity_1        (e1),
        .entity_2        (e2),
        .entity_3        (e3),
        .entity_4        (e4),
        .entity_5        (e5),
        .entity_6        (e6),
        .entity_7_Array  (e7),
        .entity_8_Flip   (e8),
        .entity_9_Flip   (e9),
        .frame_committed (frame_committed),
        .wr_err          (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_committed === 1'b1) fc_cnt++;
    endtask

    task automatic wr(input logic [3:0] s, input logic [13:0] d);
        wr_valid  = 1'b1;
        wr_slot   = s;
        wr_entity = d;
        step();
        wr_valid  = 1'b0;
    endtask

    task automatic set_cnt(input logic [9:0] v, input logic [9:0] h);
        counter_V = v;
        counter_H = h;
    endtask

    task automatic chk_all_empty(input string tag);
        chk({tag, "_all"}, {e1 == EMP, e2 == EMP, e3 == EMP,
                            e4 == EMP, e5 == EMP, e6 == EMP,
                            e7 == EMP, e8 == EMP, e9 == EMP},
            32'h1FF);
    endtask

    initial begin
        // reset state
        step();
        step();
        chk_all_empty("rst");
        chk("rst_ready", wr_ready, 0);
        chk("rst_fc", frame_committed, 0);
        chk("rst_err", wr_err, 0);
        reset = 1'b1;
        #1;
        chk("rel_ready_pre", wr_ready, 0);
        step();
        chk("rel_ready_post", wr_ready, 1);
        chk("rel_fc", fc_cnt, 0);

        // write slot 3 mid-frame, commit at (480,0)
        set_cnt(10'd100, 10'd50);
        wr(4'd3, 14'h1A25);
        step();
        step();
        chk("w3_hold", e4, EMP);
        set_cnt(10'd480, 10'd0);
        step();
        set_cnt(10'd480, 10'd1);
        chk("w3_t1_e4", e4, EMP);
        chk("w3_t1_rdy", wr_ready, 1);
        step();
        chk("w3_t2_rdy", wr_ready, 0);
        chk("w3_t2_e4", e4, EMP);
        step();
        chk("w3_commit_e4", e4, 14'h1A25);
        chk("w3_fc", frame_committed, 1);
        chk("w3_e1", e1, EMP);
        step();
        chk("w3_fc_off", frame_committed, 0);
        chk("w3_fc_cnt", fc_cnt, 1);

        // no writes across a frame
        fc_cnt = 0;
        set_cnt(10'd480, 10'd0);
        step();
        set_cnt(10'd481, 10'd0);
        for (int i = 0; i < 4; i++) step();
        chk("nowr_fc", fc_cnt, 0);
        chk("nowr_e4", e4, 14'h1A25);

        // counters held at the commit point for 10 clocks
        set_cnt(10'd10, 10'd0);
        wr(4'd0, 14'h0123);
        set_cnt(10'd480, 10'd0);
        for (int i = 0; i < 10; i++) step();
        set_cnt(10'd0, 10'd0);
        step();
        step();
        chk("hold_fc_cnt", fc_cnt, 1);
        chk("hold_e1", e1, 14'h0123);

        // out-of-range slot
        fc_cnt = 0;
        wr_valid  = 1'b1;
        wr_slot   = 4'd12;
        wr_entity = 14'h2222;
        chk("bad_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        chk("bad_err", wr_err, 1);
        step();
        chk("bad_err_off", wr_err, 0);
        set_cnt(10'd480, 10'd0);
        step();
        set_cnt(10'd0, 10'd0);
        for (int i = 0; i < 4; i++) step();
        chk("bad_fc", fc_cnt, 0);
        chk("bad_e1", e1, 14'h0123);
        chk("bad_e4", e4, 14'h1A25);

        // clear_req coincident with trigger
        wr(4'd5, 14'h0F0F);
        wr(4'd8, 14'h1234);
        clear_req = 1'b1;
        set_cnt(10'd480, 10'd0);
        step();
        clear_req = 1'b0;
        set_cnt(10'd480, 10'd1);
        chk("clr_rdy_clear", wr_ready, 0);
        step();
        chk("clr_rdy_idle", wr_ready, 1);
        chk("clr_e1_old", e1, 14'h0123);
        step();
        chk("clr_rdy_commit", wr_ready, 0);
        chk("clr_e4_old", e4, 14'h1A25);
        step();
        chk_all_empty("clr");
        chk("clr_fc", frame_committed, 1);
        step();
        chk("clr_fc_cnt", fc_cnt, 1);
        set_cnt(10'd0, 10'd0);

        // load a live value, then reset during a commit
        wr(4'd2, 14'h0AAA);
        set_cnt(10'd480, 10'd0);
        step();
        set_cnt(10'd0, 10'd0);
        step();
        step();
        chk("pre_e3", e3, 14'h0AAA);
        wr(4'd1, 14'h0555);
        set_cnt(10'd480, 10'd0);
        step();
        set_cnt(10'd0, 10'd0);
        step();
        chk("mid_commit_rdy", wr_ready, 0);
        reset = 1'b0;
        #1;
        chk_all_empty("arst");
        chk("arst_rdy", wr_ready, 0);
        chk("arst_fc", frame_committed, 0);
        step();
        reset = 1'b1;
        fc_cnt = 0;
        step();
        chk("post_rdy", wr_ready, 1);
        for (int i = 0; i < 5; i++) step();
        chk("post_fc", fc_cnt, 0);
        chk("post_e2", e2, EMP);
        chk("post_e3", e3, EMP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
